// File: rtl/ddr_cmd_packer_pkg.sv
// Shared definitions for the DDR4 command packer: command codes, bundle layout, FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ddr_cmd_pkg;

  localparam int SLOT_WIDTH   = 32;
  localparam int NUM_SLOTS    = 4;
  localparam int CMD_WIDTH    = 128;
  localparam int WDATA_WIDTH  = 512;
  localparam int BUNDLE_WIDTH = CMD_WIDTH + WDATA_WIDTH;

  // Command word field offsets
  localparam int TYPE_LSB = 0;
  localparam int BANK_LSB = 3;
  localparam int BG_LSB   = 5;
  localparam int ADDR_LSB = 7;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_PRE = 3'd1,
    CMD_ACT = 3'd2,
    CMD_RD  = 3'd3,
    CMD_WR  = 3'd4,
    CMD_REF = 3'd5,
    CMD_ZQ  = 3'd6
  } cmd_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    WAIT_WD = 2'd2
  } state_e;

  // Bundle as seen by the decoder: write data on top, command slots below.
  typedef struct packed {
    logic [WDATA_WIDTH-1:0]                wdata;
    logic [NUM_SLOTS-1:0][SLOT_WIDTH-1:0]  slots;
  } bundle_t;

  function automatic logic is_wr(input logic [2:0] cmd_type);
    return cmd_type == CMD_WR;
  endfunction

endpackage

// File: rtl/ddr_cmd_packer.sv
// Packs up to 4 DDR4 command words plus one optional 512-bit write beat into a 640-bit bundle.
// Latency: 4th command handshake in cycle N gives out_valid in cycle N+2 when write data is ready.
// Backpressure: none downstream (single-cycle strobe); upstream held via cmd_tready/wdata_tready. Optional counters: DDR_CMD_PACKER_PERF_CNT_EN.
module ddr_cmd_packer
  import ddr_cmd_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 16,
  parameter int TIMER_WIDTH   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  cmd_tdata,
  input  logic         cmd_tvalid,
  output logic         cmd_tready,
  input  logic [511:0] wdata_tdata,
  input  logic         wdata_tvalid,
  output logic         wdata_tready,
  input  logic         flush,
  output logic [639:0] out_data,
  output logic         out_valid,
  output logic         busy
`ifdef DDR_CMD_PACKER_PERF_CNT_EN
  ,
  output logic [31:0]  bundle_cnt,
  output logic [31:0]  nop_pad_cnt
`endif
);

  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX   = '1;
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_VAL = TIMER_WIDTH'(FLUSH_TIMEOUT);

  state_e                               state;
  logic [NUM_SLOTS-1:0][SLOT_WIDTH-1:0] slots;
  logic [2:0]                           cnt;
  logic                                 has_wr;
  logic [TIMER_WIDTH-1:0]               timer;

  logic    in_wr;
  logic    conflict;
  logic    timeout_hit;
  logic    close;
  logic    cmd_acc;
  logic    wd_acc;
  logic    emit;
  bundle_t emit_bundle;

  // Close detection and handshake qualification; a close cycle never accepts a command
  always_comb begin
    in_wr        = is_wr(cmd_tdata[TYPE_LSB +: 3]);
    conflict     = cmd_tvalid && in_wr && has_wr;
    timeout_hit  = (FLUSH_TIMEOUT != 0) && (timer == TIMEOUT_VAL);
    close        = (state == FILL) && ((cnt == 3'd4) || flush || timeout_hit || conflict);
    cmd_tready   = !rst && ((state == IDLE) || ((state == FILL) && !close));
    wdata_tready = !rst && ((close && has_wr) || (state == WAIT_WD));
    cmd_acc      = cmd_tvalid && cmd_tready;
    wd_acc       = wdata_tvalid && wdata_tready;
    emit         = (close && !has_wr) || wd_acc;
    emit_bundle.wdata = has_wr ? wdata_tdata : '0;
    emit_bundle.slots = slots;
  end

  assign busy = (state != IDLE);

  // Packing FSM: slot fill, idle timer, write-data wait and bundle emission
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slots     <= '0;
      cnt       <= 3'd0;
      has_wr    <= 1'b0;
      timer     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_acc) begin
            slots    <= '0;
            slots[0] <= cmd_tdata;
            cnt      <= 3'd1;
            has_wr   <= in_wr;
            timer    <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (close) begin
            state <= emit ? IDLE : WAIT_WD;
          end else if (cmd_acc) begin
            slots[cnt[1:0]] <= cmd_tdata;
            cnt             <= cnt + 3'd1;
            has_wr          <= has_wr | in_wr;
            timer           <= '0;
          end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_WD: begin
          if (wd_acc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= emit_bundle;
        cnt       <= 3'd0;
        has_wr    <= 1'b0;
      end
    end
  end

`ifdef DDR_CMD_PACKER_PERF_CNT_EN
  logic [2:0] pads;
  assign pads = 3'(NUM_SLOTS) - cnt;

  // Bundle and NOP-pad counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_cnt  <= '0;
      nop_pad_cnt <= '0;
    end else if (emit) begin
      bundle_cnt  <= bundle_cnt + 32'd1;
      nop_pad_cnt <= nop_pad_cnt + 32'(pads);
    end
  end
`endif

endmodule

// File: tb/tb_ddr_cmd_packer.sv
// Scoreboard bench for ddr_cmd_packer: directed scenarios plus randomized bundles.
// Expected bundles are built from the command lists the bench issues and pushed into a queue.
// A monitor pops and compares on every out_valid; a separate process feeds write-data beats.
module tb_ddr_cmd_packer;

  logic         clk;
  logic         rst;
  logic [31:0]  cmd_tdata;
  logic         cmd_tvalid;
  logic         cmd_tready;
  logic [511:0] wdata_tdata;
  logic         wdata_tvalid;
  logic         wdata_tready;
  logic         flush;
  logic [639:0] out_data;
  logic         out_valid;
  logic         busy;
`ifdef DDR_CMD_PACKER_PERF_CNT_EN
  logic [31:0]  bundle_cnt;
  logic [31:0]  nop_pad_cnt;
`endif

  ddr_cmd_packer #(.FLUSH_TIMEOUT(16), .TIMER_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_tdata    (cmd_tdata),
    .cmd_tvalid   (cmd_tvalid),
    .cmd_tready   (cmd_tready),
    .wdata_tdata  (wdata_tdata),
    .wdata_tvalid (wdata_tvalid),
    .wdata_tready (wdata_tready),
    .flush        (flush),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .busy         (busy)
`ifdef DDR_CMD_PACKER_PERF_CNT_EN
    ,
    .bundle_cnt   (bundle_cnt),
    .nop_pad_cnt  (nop_pad_cnt)
`endif
  );

  typedef struct {
    logic [639:0] data;
    int           pads;
  } exp_t;

  exp_t         exp_q[$];
  logic [511:0] wd_q[$];
  bit           wd_en = 1'b1;
  int           n_chk = 0;
  int           n_pass = 0;
  int           n_emit = 0;
  int           pad_sum = 0;
  bit           carry_wr = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input bit ok, input string name, input logic [639:0] act, input logic [639:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [31:0] mk_cmd(input int t);
    logic [31:0] c;
    c      = $urandom();
    c[2:0] = 3'(t);
    return c;
  endfunction

  function automatic int rand_non_wr();
    int nt[6] = '{0, 1, 2, 3, 5, 6};
    return nt[$urandom_range(0, 5)];
  endfunction

  // Reference: commands fill slots in order, unused slots zero, data only when a WR is present
  function automatic exp_t make_exp(input logic [31:0] c[$], input logic [511:0] d);
    exp_t e;
    e.data = '0;
    for (int i = 0; i < c.size(); i++) e.data[32*i +: 32] = c[i];
    e.data[639:128] = d;
    e.pads = 4 - c.size();
    return e;
  endfunction

  task automatic send_cmd(input logic [31:0] c, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    cmd_tdata  = c;
    cmd_tvalid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_tready;
      @(posedge clk);
      #1;
      if (!ok) waited++;
    end
    cmd_tvalid = 1'b0;
    if (!ok) chk(1'b0, "cmd_handshake_timeout", 0, 1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (wd_q.size() == 0) && !busy;
    end
    @(posedge clk);
    #1;
    if (!done) chk(1'b0, "wait_idle_timeout", 0, 1);
  endtask

  // One bundle of n commands; close_kind 0 full, 1 flush, 2 idle timeout, 3 WR conflict
  task automatic run_bundle(input int n, input bit want_wr, input int close_kind);
    logic [31:0]  cmds[$];
    logic [511:0] d;
    logic [31:0]  c;
    int           wr_pos;
    int           w;
    d = '0;
    wr_pos = carry_wr ? 0 : (want_wr ? int'($urandom_range(0, n - 1)) : -1);
    carry_wr = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == wr_pos) begin
        c = mk_cmd(4);
        d = rand512();
        wd_q.push_back(d);
      end else begin
        c = mk_cmd(rand_non_wr());
      end
      if (i > 0) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1;
      end
      send_cmd(c, w);
      cmds.push_back(c);
      if (i == 0) chk(exp_q.size() == 0, "accept_after_prev_emit", exp_q.size(), 0);
      else        chk(w == 0, "fill_accept_no_wait", w, 0);
    end
    exp_q.push_back(make_exp(cmds, d));
    if (n < 4) begin
      case (close_kind)
        1: pulse_flush();
        2: begin repeat (24) @(posedge clk); #1; end
        default: carry_wr = 1'b1;
      endcase
    end
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        n_emit++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_bundle", out_data, 0);
        end else begin
          e = exp_q.pop_front();
          pad_sum += e.pads;
          chk(out_data == e.data, "bundle_data", out_data, e.data);
`ifdef DDR_CMD_PACKER_PERF_CNT_EN
          chk(bundle_cnt == 32'(n_emit), "bundle_cnt", bundle_cnt, n_emit);
          chk(nop_pad_cnt == 32'(pad_sum), "nop_pad_cnt", nop_pad_cnt, pad_sum);
`endif
        end
      end
    end
  end

  // Write-data feeder: beats in WR order, random gaps, held until consumed
  initial begin
    bit ok;
    wdata_tvalid = 1'b0;
    wdata_tdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (wd_en && wd_q.size() > 0) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        wdata_tdata  = wd_q[0];
        wdata_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
          @(negedge clk);
          ok = wdata_tready;
          @(posedge clk);
          #1;
        end
        if (!ok) chk(1'b0, "wdata_handshake_timeout", 0, 1);
        void'(wd_q.pop_front());
        wdata_tvalid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cmds[$];
    logic [511:0] d1, d2;
    int w, e0, n, kind;
    bit wr;

    rst = 1'b1; flush = 1'b0; cmd_tvalid = 1'b0; cmd_tdata = '0;
    repeat (2) @(negedge clk);
    chk(out_valid == 1'b0, "reset_out_valid", out_valid, 0);
    chk(out_data == '0, "reset_out_data", out_data, 0);
    chk(busy == 1'b0, "reset_busy", busy, 0);
    chk(cmd_tready == 1'b0, "reset_cmd_tready", cmd_tready, 0);
    chk(wdata_tready == 1'b0, "reset_wdata_tready", wdata_tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(cmd_tready == 1'b1, "idle_cmd_tready", cmd_tready, 1);
    chk(wdata_tready == 1'b0, "idle_wdata_tready", wdata_tready, 0);
    @(posedge clk); #1;

    // Four back-to-back commands, latency N+2
    cmds = {mk_cmd(2), mk_cmd(3), mk_cmd(3), mk_cmd(1)};
    for (int i = 0; i < 4; i++) send_cmd(cmds[i], w);
    exp_q.push_back(make_exp(cmds, '0));
    @(negedge clk);
    chk(out_valid == 1'b0, "latency_n1", out_valid, 0);
    @(negedge clk);
    chk(out_valid == 1'b1, "latency_n2", out_valid, 1);
    @(posedge clk); #1;
    wait_idle();

    // Single ACT closed by idle timeout
    cmds = {mk_cmd(2)};
    send_cmd(cmds[0], w);
    exp_q.push_back(make_exp(cmds, '0));
    e0 = n_emit;
    repeat (15) @(negedge clk);
    chk(n_emit == e0, "no_early_timeout", n_emit, e0);
    repeat (10) @(negedge clk);
    chk(n_emit == e0 + 1, "timeout_emit", n_emit, e0 + 1);
    @(posedge clk); #1;
    wait_idle();

    // WR with late write data
    wd_en = 1'b0;
    d1 = rand512();
    wd_q.push_back(d1);
    cmds = {mk_cmd(4)};
    send_cmd(cmds[0], w);
    exp_q.push_back(make_exp(cmds, d1));
    e0 = n_emit;
    pulse_flush();
    repeat (5) @(negedge clk);
    chk(busy == 1'b1, "wait_wd_busy", busy, 1);
    chk(cmd_tready == 1'b0, "wait_wd_cmd_tready", cmd_tready, 0);
    chk(wdata_tready == 1'b1, "wait_wd_wdata_tready", wdata_tready, 1);
    chk(n_emit == e0, "wait_wd_no_emit", n_emit, e0);
    @(posedge clk); #1;
    wd_en = 1'b1;
    wait_idle();

    // WR, RD, then conflicting WR starts the next bundle
    d1 = rand512(); d2 = rand512();
    wd_q.push_back(d1);
    cmds = {mk_cmd(4), mk_cmd(3)};
    send_cmd(cmds[0], w);
    send_cmd(cmds[1], w);
    exp_q.push_back(make_exp(cmds, d1));
    wd_q.push_back(d2);
    cmds = {mk_cmd(4)};
    send_cmd(cmds[0], w);
    chk(exp_q.size() == 0, "conflict_wr_after_emit", exp_q.size(), 0);
    cmds.push_back(mk_cmd(2));
    send_cmd(cmds[1], w);
    exp_q.push_back(make_exp(cmds, d2));
    pulse_flush();
    wait_idle();

    // Flush in IDLE is ignored; flush after two commands
    e0 = n_emit;
    pulse_flush();
    repeat (3) @(negedge clk);
    chk(n_emit == e0, "idle_flush_no_emit", n_emit, e0);
    chk(busy == 1'b0, "idle_flush_busy", busy, 0);
    @(posedge clk); #1;
    cmds = {mk_cmd(5), mk_cmd(6)};
    send_cmd(cmds[0], w);
    send_cmd(cmds[1], w);
    exp_q.push_back(make_exp(cmds, '0));
    pulse_flush();
    wait_idle();

    // Reset with three slots filled discards the bundle
    cmds = {mk_cmd(2), mk_cmd(3), mk_cmd(1)};
    for (int i = 0; i < 3; i++) send_cmd(cmds[i], w);
    rst = 1'b1;
    @(negedge clk);
    chk(cmd_tready == 1'b0, "rst_mid_cmd_tready", cmd_tready, 0);
    chk(wdata_tready == 1'b0, "rst_mid_wdata_tready", wdata_tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pad_sum = 0;
    n_emit = 0;
    @(negedge clk);
    chk(busy == 1'b0, "rst_mid_busy", busy, 0);
    @(posedge clk); #1;
    cmds = {mk_cmd(2), mk_cmd(4), mk_cmd(3), mk_cmd(1)};
    d1 = rand512();
    wd_q.push_back(d1);
    for (int i = 0; i < 4; i++) send_cmd(cmds[i], w);
    exp_q.push_back(make_exp(cmds, d1));
    wait_idle();

    // Randomized bundles
    for (int b = 0; b < 40; b++) begin
      n    = $urandom_range(1, 4);
      wr   = ($urandom_range(0, 1) == 1);
      kind = (n == 4) ? 0 : int'($urandom_range(1, (wr || carry_wr) ? 3 : 2));
      run_bundle(n, wr, kind);
    end
    if (carry_wr) run_bundle(1, 1'b0, 1);
    wait_idle();
    chk(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
